mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
// - MEM stage of the 5-stage pipeline: sits between EX_MEM and MEM_WB, performs load/store for the
//   instruction held in EX_MEM and drives Read_Data into MEM_WB.
// - req/ack handshake to data memory; stalls the pipeline until the access completes.
// - Handles byte/half/word lanes, sign/zero extension, misalignment detection and bus timeout.
// PARAMETERS
// - MAX_WAIT  default 255  BUSY cycles without ack before a bus error is declared (1..255)
// PORTS
// - clk_i         in   1   clock, rising edge
// - rst_i         in   1   reset, asynchronous, active-low
// - valid_i       in   1   EX_MEM holds a live instruction
// - mem_read_i    in   1   instruction is a load
// - mem_write_i   in   1   instruction is a store
// - funct3_i      in   3   000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores: 000 sb, 001 sh, 010 sw)
// - addr_i        in   32  effective address (EX_MEM ALU result)
// - wdata_i       in   32  store data (rs2)
// - stall_o       out  1   hold PC, IF_ID, ID_EX, EX_MEM; MEM_WB captures only when 0
// - read_data_o   out  32  extended load data to MEM_WB Read_Data_i
// - misalign_o    out  1   combinational: current access misaligned
// - bus_err_o     out  1   sticky timeout flag
// - dmem_req_o    out  1   memory request, held until ack
// - dmem_we_o     out  1   1 = write
// - dmem_addr_o   out  32  word-aligned address ({addr[31:2],2'b00})
// - dmem_wdata_o  out  32  lane-replicated store data
// - dmem_be_o     out  4   byte enables, little-endian
// - dmem_ack_i    in   1   one-cycle completion strobe
// - dmem_rdata_i  in   32  read word, valid with ack
// BEHAVIOUR
// - Reset: state IDLE; req, we, be, addr, wdata, read_data_o, bus_err_o, wait counter all 0.
// - access = valid_i & (mem_read_i | mem_write_i) & ~misalign_o; read+write both set -> write.
// - misalign_o = valid_i & access type & (lh/lhu/sh: addr[0]; lw/sw: addr[1:0]!=0).
//   Misaligned: no request, no stall, store suppressed, read_data_o <= 0.
// - funct3 011/110/111 decode as word.
// - FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: on access, latch addr/be/wdata/we/funct3, req=1 from next cycle, go BUSY; stall_o=1.
//   BUSY: req held, stall_o=1, counter++. ack -> req=0, loads latch extended data, go DONE.
//   BUSY timeout: counter==MAX_WAIT without ack -> req=0, bus_err_o=1, read_data_o=0, go DONE.
//   Ack on the timeout cycle: ack wins, no error.
//   DONE: stall_o=0, read_data_o stable, pipeline advances at end of cycle, go IDLE.
// - Memory op costs 3 cycles (IDLE, BUSY >=1, DONE) plus memory wait.
// - Non-memory instructions: stall_o=0; read_data_o holds its value.
// - dmem_ack_i outside BUSY is ignored.
// - Store lanes:
//   sb: be=1<<addr[1:0], wdata={4{b}}.
//   sh: be=addr[1]?1100:0011, wdata={2{h}}.
//   sw: be=1111.
// - Load: select lane by latched addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend.
// - Reset mid-operation: immediate return to reset values; pending request abandoned.
// STRUCTURE
// - Shared package/include dmem_defs: funct3 size codes, FSM state encoding.
// - Sub-module lane_align (combinational): store be/wdata generation, load extract/extend.
// - Top keeps FSM, wait counter, latched request registers, read_data_o.
// TESTING
// - lw addr 0x100, ack after 2 cycles, rdata 0xDEADBEEF
//   -> req at addr 0x100, be 1111, stall 3 cycles, read_data_o=0xDEADBEEF in DONE.
// - lb addr 0x103, rdata 0x80000000 -> 0xFFFFFF80.
// - lbu, same address and data -> 0x00000080.
// - sh addr 0x102, wdata 0x1234ABCD -> we=1, be=1100, dmem_wdata_o=0xABCDABCD,
//   addr 0x100, read_data_o unchanged.
// - lw addr 0x101 -> misalign_o=1, no dmem_req_o, stall_o=0, read_data_o=0.
// - No ack, MAX_WAIT=4 -> req dropped after 4 BUSY cycles, bus_err_o=1 and sticky, DONE with data 0.
// - rst_i low during BUSY -> req=0, state IDLE; a later ack is ignored.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared data-memory definitions for the MEM stage.
// - access size codes (funct3[1:0]); funct3[2] selects zero extension on loads
// - FSM state encoding for the memory handshake
// - latched request record and the alignment rule
package mem_access_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  // 2'b10 and 2'b11 both decode as word

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;    // word aligned
    logic [1:0]  off;     // byte offset inside the word
    logic [3:0]  be;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// lane_align: combinational byte-lane steering for the MEM stage.
// Ports:
//   i_st_size/i_st_off/i_st_data -> o_st_be/o_st_wdata : store byte enables and
//                                    lane-replicated store data
//   i_ld_funct3/i_ld_off/i_ld_rdata -> o_ld_data      : extracted, extended load data
module lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shift;
  logic [15:0] w_half;
  logic        w_zext;

  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_data;
    case (i_st_size)
      SZ_BYTE: begin
        o_st_be    = 4'b0001 << i_st_off;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_st_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = i_ld_rdata >> {i_ld_off, 3'b000};
  assign w_half  = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
  assign w_zext  = i_ld_funct3[2];

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_funct3[1:0])
      SZ_BYTE: o_ld_data = {{24{~w_zext & w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: o_ld_data = {{16{~w_zext & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage between EX_MEM and MEM_WB.
// Issues one req/ack data-memory access per load/store, stalling the pipeline
// until it completes (IDLE -> BUSY -> DONE -> IDLE).
// Ports:
//   clk_i, rst_i (async, active low)
//   valid_i, mem_read_i, mem_write_i, funct3_i, addr_i, wdata_i : from EX_MEM
//   stall_o, read_data_o, misalign_o, bus_err_o                  : to pipeline / MEM_WB
//   dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
//   dmem_ack_i, dmem_rdata_i                                     : data memory bus
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] read_data_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

  state_e      r_state, w_next;
  dmem_req_t   r_lat;
  logic        r_req;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;

  logic        w_memop, w_mis, w_access;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata, w_ld_data;

  assign w_memop   = valid_i & (mem_read_i | mem_write_i);
  assign w_mis     = w_memop & is_misaligned(funct3_i[1:0], addr_i[1:0]);
  assign w_access  = w_memop & ~w_mis;
  // counter holds completed BUSY cycles; this cycle is number w_cnt_inc
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_timeout = (w_cnt_inc == LP_MAX);

  lane_align u_lane (
    .i_st_size   (funct3_i[1:0]),
    .i_st_off    (addr_i[1:0]),
    .i_st_data   (wdata_i),
    .o_st_be     (w_st_be),
    .o_st_wdata  (w_st_wdata),
    .i_ld_funct3 (r_lat.funct3),
    .i_ld_off    (r_lat.off),
    .i_ld_rdata  (dmem_rdata_i),
    .o_ld_data   (w_ld_data)
  );

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_access) w_next = ST_BUSY;
      ST_BUSY: if (dmem_ack_i || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    stall_o = 1'b0;
    case (r_state)
      ST_IDLE: stall_o = w_access;
      ST_BUSY: stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  // request latch, wait counter, load result
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_lat   <= '0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_lat.we     <= mem_write_i;   // read+write together counts as a store
            r_lat.funct3 <= funct3_i;
            r_lat.addr   <= {addr_i[31:2], 2'b00};
            r_lat.off    <= addr_i[1:0];
            r_lat.be     <= w_st_be;
            r_lat.wdata  <= w_st_wdata;
            r_req        <= 1'b1;
            r_cnt        <= '0;
          end else if (w_mis) begin
            r_rdata <= '0;
          end
        end
        ST_BUSY: begin
          r_cnt <= w_cnt_inc;
          if (dmem_ack_i) begin            // ack beats a same-cycle timeout
            r_req <= 1'b0;
            if (!r_lat.we) r_rdata <= w_ld_data;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign misalign_o   = w_mis;
  assign bus_err_o    = r_err;
  assign read_data_o  = r_rdata;
  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_lat.we;
  assign dmem_addr_o  = r_lat.addr;
  assign dmem_wdata_o = r_lat.wdata;
  assign dmem_be_o    = r_lat.be;

endmodule
